ddr_cas_scheduler: RTL and testbench

- Sits directly downstream of the activate stage in the DDR4 controller.
- Captures each ACT event (act_rdy with rw type and address) into a small pending queue.
- Enforces tRCD from the ACT and tCCD between successive CAS, then issues the RD/WR CAS (cas_rdy, cas_rw).
- After CL (read) or CWL (write) plus preamble, it pulses rw_rdy to the data stage. It also drives the cas_idle/act_stall status used by the activate stage.

---
 rtl/ddr_cas_scheduler_pkg.sv | 29 ++
 rtl/ddr_cas_scheduler_if.sv | 25 ++
 rtl/ddr_cas_scheduler_lat.sv | 47 ++++
 rtl/ddr_cas_scheduler.sv | 109 ++++++++++
 tb/tb_ddr_cas_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_cas_scheduler_pkg.sv
// Shared types and defaults for the DDR4 CAS scheduling stage.
package ddr_package;

  localparam int unsigned TRCD_DEF    = 16;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned MAX_LAT_DEF = 32;
  localparam int unsigned CW_DEF      = 6;
  localparam int unsigned TRCD_W      = 8;

  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  typedef struct packed {
    logic [1:0] bg;
    logic [1:0] ba;
    logic [9:0] col;
  } mem_addr_type;

  typedef struct packed {
    logic [1:0]        rw;
    mem_addr_type      addr;
    logic [TRCD_W-1:0] trcd_cnt;
  } cas_entry_t;

  function automatic logic rw_valid(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

endpackage

// File: rtl/ddr_cas_scheduler_if.sv
// ACT-in / CAS-out / data-stage handshake bundle of the CAS scheduler.
import ddr_package::*;

interface ddr_cas_scheduler_if;
  logic         act_rdy;
  logic [1:0]   act_rw;
  mem_addr_type act_addr;
  logic         act_stall;
  logic         cas_rdy;
  logic [1:0]   cas_rw;
  mem_addr_type cas_addr;
  logic         rw_rdy;
  logic [1:0]   dimm_rd;
  logic         cas_idle;

  modport master (
    output act_rdy, act_rw, act_addr,
    input  act_stall, cas_rdy, cas_rw, cas_addr, rw_rdy, dimm_rd, cas_idle
  );

  modport slave (
    input  act_rdy, act_rw, act_addr,
    output act_stall, cas_rdy, cas_rw, cas_addr, rw_rdy, dimm_rd, cas_idle
  );
endinterface

// File: rtl/ddr_cas_scheduler_lat.sv
// CAS-to-data latency pipeline: loads {valid,rw} at a stage index, shifts toward stage 1.
module ddr_lat_pipe #(
  parameter int unsigned MAX_LAT = 32,
  parameter int unsigned IW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic [1:0]    load_rw,
  output logic          rw_rdy,
  output logic [1:0]    dimm_rd,
  output logic          busy_c
);

  logic [MAX_LAT:1]       vld, vld_nxt;
  logic [MAX_LAT:1][1:0]  rwq, rwq_nxt;

  // Shift by one stage; an issue overwrites only its own stage.
  always_comb begin
    vld_nxt = {1'b0, vld[MAX_LAT:2]};
    rwq_nxt = {2'b00, rwq[MAX_LAT:2]};
    for (int i = 1; i <= int'(MAX_LAT); i++) begin
      if (load && (load_idx == IW'(i))) begin
        vld_nxt[i] = 1'b1;
        rwq_nxt[i] = load_rw;
      end
    end
  end

  assign busy_c = |vld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld     <= '0;
      rwq     <= '0;
      rw_rdy  <= 1'b0;
      dimm_rd <= 2'b00;
    end else begin
      vld     <= vld_nxt;
      rwq     <= rwq_nxt;
      rw_rdy  <= vld[1];
      dimm_rd <= vld[1] ? rwq[1] : 2'b00;
    end
  end

endmodule

// File: rtl/ddr_cas_scheduler.sv
// In-order CAS issue after tRCD/tCCD, with CL/CWL-timed data-phase strobe.
module ddr_cas_scheduler import ddr_package::*; #(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TRCD    = TRCD_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  ddr_cas_scheduler_if.slave    bus,
  input  logic [CW-1:0]         CL,
  input  logic [CW-1:0]         CWL,
  input  logic [1:0]            RD_PRE,
  input  logic [1:0]            WR_PRE,
  input  logic [CW-1:0]         tCCD,
  input  logic                  config_done,
  output logic                  ovf_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = CW + 2;
  localparam int unsigned IW = $clog2(MAX_LAT + 1);

  cas_entry_t      q [DEPTH];
  cas_entry_t      head;
  logic [PW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   ccd_cnt;
  logic            empty, full, issue_now, enq, pipe_busy;
  logic [LW-1:0]   lat_raw;
  logic [IW-1:0]   lat_idx;

  // Decision is made one cycle ahead of the registered strobe, so the head
  // qualifies once its counter will have reached zero by the cas_rdy cycle.
  always_comb begin
    head      = q[rd_ptr[PW-1:0]];
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    issue_now = !empty && (head.trcd_cnt <= TRCD_W'(1)) && (ccd_cnt == '0) && config_done;
  end

  assign bus.act_stall = full & ~issue_now;
  assign enq           = bus.act_rdy & rw_valid(bus.act_rw) & ~bus.act_stall;

  // Data-phase latency with clamp to [1, MAX_LAT].
  always_comb begin
    lat_raw = (head.rw == RW_READ) ? (LW'(CL) + LW'(RD_PRE)) : (LW'(CWL) + LW'(WR_PRE));
    lat_idx = IW'(lat_raw);
    if (lat_raw > LW'(MAX_LAT)) begin
      lat_idx = IW'(MAX_LAT);
    end else if (lat_raw == '0) begin
      lat_idx = IW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
      wr_ptr <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (q[i].trcd_cnt != '0) q[i].trcd_cnt <= q[i].trcd_cnt - TRCD_W'(1);
      end
      if (enq) begin
        q[wr_ptr[PW-1:0]] <= '{rw: bus.act_rw, addr: bus.act_addr,
                               trcd_cnt: TRCD_W'(TRCD - 1)};
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      ccd_cnt      <= '0;
      ovf_err      <= 1'b0;
      bus.cas_rdy  <= 1'b0;
      bus.cas_rw   <= 2'b00;
      bus.cas_addr <= '0;
      bus.cas_idle <= 1'b1;
    end else begin
      if (issue_now) begin
        rd_ptr  <= rd_ptr + (PW+1)'(1);
        ccd_cnt <= tCCD - CW'(1);
      end else if (ccd_cnt != '0) begin
        ccd_cnt <= ccd_cnt - CW'(1);
      end
      ovf_err      <= ovf_err | (bus.act_rdy & rw_valid(bus.act_rw) & bus.act_stall);
      bus.cas_rdy  <= issue_now;
      bus.cas_rw   <= issue_now ? head.rw : 2'b00;
      bus.cas_addr <= issue_now ? head.addr : '0;
      bus.cas_idle <= empty & ~pipe_busy & ~enq;
    end
  end

  ddr_lat_pipe #(
    .MAX_LAT (MAX_LAT),
    .IW      (IW)
  ) u_lat_pipe (
    .clock    (clock),
    .reset    (reset),
    .load     (issue_now),
    .load_idx (lat_idx),
    .load_rw  (head.rw),
    .rw_rdy   (bus.rw_rdy),
    .dimm_rd  (bus.dimm_rd),
    .busy_c   (pipe_busy)
  );

endmodule

// File: tb/tb_ddr_cas_scheduler.sv
// Directed-vector bench for ddr_cas_scheduler (TRCD=16, DEPTH=4, MAX_LAT=32).
module tb_ddr_cas_scheduler;
  import ddr_package::*;

  localparam int unsigned CW = 6;

  logic          clock;
  logic          reset;
  logic [CW-1:0] cl, cwl, tccd;
  logic [1:0]    rd_pre, wr_pre;
  logic          config_done;
  logic          ovf_err;

  ddr_cas_scheduler_if bus ();

  ddr_cas_scheduler #(.DEPTH(4), .TRCD(16), .MAX_LAT(32), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .CL          (cl),
    .CWL         (cwl),
    .RD_PRE      (rd_pre),
    .WR_PRE      (wr_pre),
    .tCCD        (tccd),
    .config_done (config_done),
    .ovf_err     (ovf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int           cas_cyc[$];
  logic [1:0]   cas_rw_q[$];
  mem_addr_type cas_addr_q[$];
  int           rw_cyc[$];
  logic [1:0]   rw_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.cas_rdy) begin
        cas_cyc.push_back(cyc);
        cas_rw_q.push_back(bus.cas_rw);
        cas_addr_q.push_back(bus.cas_addr);
      end
      if (bus.rw_rdy) begin
        rw_cyc.push_back(cyc);
        rw_q.push_back(bus.dimm_rd);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  function automatic mem_addr_type mk_addr(input int n);
    return mem_addr_type'(14'(n));
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic act_pulse(input logic [1:0] rw, input mem_addr_type a);
    bus.act_rdy  = 1'b1;
    bus.act_rw   = rw;
    bus.act_addr = a;
    tick();
    bus.act_rdy  = 1'b0;
    bus.act_rw   = 2'b00;
  endtask

  task automatic clear_log;
    cas_cyc.delete(); cas_rw_q.delete(); cas_addr_q.delete();
    rw_cyc.delete();  rw_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (bus.cas_rdy !== 1'b0)  begin errors++; $display("FAIL reset_cas_rdy: got %b want 0", bus.cas_rdy); end
    checks++; if (bus.cas_rw !== 2'b00)  begin errors++; $display("FAIL reset_cas_rw: got %b want 00", bus.cas_rw); end
    checks++; if (bus.cas_addr !== mk_addr(0)) begin errors++; $display("FAIL reset_cas_addr: got %h want 0", bus.cas_addr); end
    checks++; if (bus.rw_rdy !== 1'b0)   begin errors++; $display("FAIL reset_rw_rdy: got %b want 0", bus.rw_rdy); end
    checks++; if (bus.dimm_rd !== 2'b00) begin errors++; $display("FAIL reset_dimm_rd: got %b want 00", bus.dimm_rd); end
    checks++; if (bus.act_stall !== 1'b0) begin errors++; $display("FAIL reset_act_stall: got %b want 0", bus.act_stall); end
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL reset_cas_idle: got %b want 1", bus.cas_idle); end
    checks++; if (ovf_err !== 1'b0)      begin errors++; $display("FAIL reset_ovf_err: got %b want 0", ovf_err); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b want 1", bus.cas_idle); end
  endtask

  task automatic test_single_read;
    int t0;
    cl = 6'd11; rd_pre = 2'd1; tccd = 6'd4; config_done = 1'b1;
    clear_log();
    t0 = cyc;
    act_pulse(RW_READ, mk_addr(5));
    repeat (27) tick();
    checks++; if (bus.cas_idle !== 1'b0) begin errors++; $display("FAIL single_idle_c28: got %b want 0", bus.cas_idle); end
    tick();
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL single_idle_c29: got %b want 1", bus.cas_idle); end
    checks++;
    if (cas_cyc.size() != 1 || rw_cyc.size() != 1) begin
      errors++; $display("FAIL single_counts: got cas=%0d rw=%0d want 1/1", cas_cyc.size(), rw_cyc.size());
    end else begin
      checks++; if (cas_cyc[0] - t0 != 16) begin errors++; $display("FAIL single_cas_cycle: got %0d want 16", cas_cyc[0] - t0); end
      checks++; if (cas_rw_q[0] !== RW_READ) begin errors++; $display("FAIL single_cas_rw: got %b want 10", cas_rw_q[0]); end
      checks++; if (cas_addr_q[0] !== mk_addr(5)) begin errors++; $display("FAIL single_cas_addr: got %h want %h", cas_addr_q[0], mk_addr(5)); end
      checks++; if (rw_cyc[0] - t0 != 28) begin errors++; $display("FAIL single_rw_cycle: got %0d want 28", rw_cyc[0] - t0); end
      checks++; if (rw_q[0] !== RW_READ) begin errors++; $display("FAIL single_dimm_rd: got %b want 10", rw_q[0]); end
    end
  endtask

  task automatic test_invalid_rw;
    clear_log();
    act_pulse(2'b11, mk_addr(7));
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL invalid_idle: got %b want 1", bus.cas_idle); end
    repeat (20) tick();
    checks++; if (cas_cyc.size() != 0) begin errors++; $display("FAIL invalid_no_cas: got %0d want 0", cas_cyc.size()); end
  endtask

  task automatic test_back_to_back;
    int t0;
    int exp_cas[3] = '{16, 20, 24};
    int exp_rw[3]  = '{26, 30, 34};
    cwl = 6'd9; wr_pre = 2'd1; tccd = 6'd4; config_done = 1'b1;
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 3; i++) act_pulse(RW_WRITE, mk_addr(10 + i));
    repeat (40) tick();
    checks++;
    if (cas_cyc.size() != 3 || rw_cyc.size() != 3) begin
      errors++; $display("FAIL b2b_counts: got cas=%0d rw=%0d want 3/3", cas_cyc.size(), rw_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (cas_cyc[i] - t0 != exp_cas[i]) begin errors++; $display("FAIL b2b_cas_cycle%0d: got %0d want %0d", i, cas_cyc[i] - t0, exp_cas[i]); end
        checks++; if (cas_addr_q[i] !== mk_addr(10 + i)) begin errors++; $display("FAIL b2b_cas_addr%0d: got %h want %h", i, cas_addr_q[i], mk_addr(10 + i)); end
        checks++; if (rw_cyc[i] - t0 != exp_rw[i]) begin errors++; $display("FAIL b2b_rw_cycle%0d: got %0d want %0d", i, rw_cyc[i] - t0, exp_rw[i]); end
        checks++; if (rw_q[i] !== RW_WRITE) begin errors++; $display("FAIL b2b_dimm_rd%0d: got %b want 01", i, rw_q[i]); end
      end
    end
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", bus.cas_idle); end
  endtask

  task automatic test_mixed;
    int t0;
    cl = 6'd11; rd_pre = 2'd1; cwl = 6'd5; wr_pre = 2'd1; tccd = 6'd4; config_done = 1'b1;
    clear_log();
    t0 = cyc;
    act_pulse(RW_READ, mk_addr(40));
    act_pulse(RW_WRITE, mk_addr(41));
    repeat (40) tick();
    checks++;
    if (cas_cyc.size() != 2 || rw_cyc.size() != 2) begin
      errors++; $display("FAIL mixed_counts: got cas=%0d rw=%0d want 2/2", cas_cyc.size(), rw_cyc.size());
    end else begin
      checks++; if (cas_cyc[1] - t0 != 20) begin errors++; $display("FAIL mixed_wr_cas: got %0d want 20", cas_cyc[1] - t0); end
      checks++; if (rw_cyc[0] - t0 != 26) begin errors++; $display("FAIL mixed_rw0_cycle: got %0d want 26", rw_cyc[0] - t0); end
      checks++; if (rw_q[0] !== RW_WRITE) begin errors++; $display("FAIL mixed_rw0_type: got %b want 01", rw_q[0]); end
      checks++; if (rw_cyc[1] - t0 != 28) begin errors++; $display("FAIL mixed_rw1_cycle: got %0d want 28", rw_cyc[1] - t0); end
      checks++; if (rw_q[1] !== RW_READ) begin errors++; $display("FAIL mixed_rw1_type: got %b want 10", rw_q[1]); end
    end
  endtask

  task automatic test_full_pop_enq;
    int t1;
    cwl = 6'd9; wr_pre = 2'd1; tccd = 6'd4; config_done = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) act_pulse(RW_WRITE, mk_addr(30 + i));
    repeat (16) tick();
    checks++; if (bus.act_stall !== 1'b1) begin errors++; $display("FAIL fpe_stall_full: got %b want 1", bus.act_stall); end
    t1 = cyc;
    config_done  = 1'b1;
    bus.act_rdy  = 1'b1;
    bus.act_rw   = RW_WRITE;
    bus.act_addr = mk_addr(34);
    #1;
    checks++; if (bus.act_stall !== 1'b0) begin errors++; $display("FAIL fpe_stall_pop: got %b want 0", bus.act_stall); end
    tick();
    bus.act_rdy = 1'b0;
    bus.act_rw  = 2'b00;
    checks++; if (bus.act_stall !== 1'b1) begin errors++; $display("FAIL fpe_still_full: got %b want 1", bus.act_stall); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fpe_no_ovf: got %b want 0", ovf_err); end
    repeat (60) tick();
    checks++;
    if (cas_cyc.size() != 5) begin
      errors++; $display("FAIL fpe_count: got %0d want 5", cas_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (cas_addr_q[i] !== mk_addr(30 + i)) begin errors++; $display("FAIL fpe_addr%0d: got %h want %h", i, cas_addr_q[i], mk_addr(30 + i)); end
      end
      checks++; if (cas_cyc[0] - t1 != 1) begin errors++; $display("FAIL fpe_first_cas: got %0d want 1", cas_cyc[0] - t1); end
      checks++; if (cas_cyc[4] - t1 != 17) begin errors++; $display("FAIL fpe_new_cas: got %0d want 17", cas_cyc[4] - t1); end
    end
  endtask

  task automatic test_overflow;
    int t0;
    int exp_cas[4] = '{16, 20, 24, 28};
    cl = 6'd11; rd_pre = 2'd1; tccd = 6'd4; config_done = 1'b0;
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 4; i++) act_pulse(RW_READ, mk_addr(20 + i));
    checks++; if (bus.act_stall !== 1'b1) begin errors++; $display("FAIL ovf_stall: got %b want 1", bus.act_stall); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf_err); end
    act_pulse(RW_READ, mk_addr(99));
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    checks++; if (cas_cyc.size() != 0) begin errors++; $display("FAIL ovf_no_cas: got %0d want 0", cas_cyc.size()); end
    config_done = 1'b1;
    repeat (50) tick();
    checks++;
    if (cas_cyc.size() != 4) begin
      errors++; $display("FAIL ovf_count: got %0d want 4", cas_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (cas_addr_q[i] !== mk_addr(20 + i)) begin errors++; $display("FAIL ovf_addr%0d: got %h want %h", i, cas_addr_q[i], mk_addr(20 + i)); end
        checks++; if (cas_cyc[i] - t0 != exp_cas[i]) begin errors++; $display("FAIL ovf_cycle%0d: got %0d want %0d", i, cas_cyc[i] - t0, exp_cas[i]); end
      end
    end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
  endtask

  task automatic test_reset_mid;
    cl = 6'd11; rd_pre = 2'd1; tccd = 6'd4; config_done = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) act_pulse(RW_READ, mk_addr(50 + i));
    repeat (15) tick();
    checks++; if (cas_cyc.size() != 1) begin errors++; $display("FAIL rmid_setup: got %0d cas want 1", cas_cyc.size()); end
    reset = 1'b1;
    #1;
    checks++; if (bus.cas_rdy !== 1'b0)  begin errors++; $display("FAIL rmid_cas_rdy: got %b want 0", bus.cas_rdy); end
    checks++; if (bus.rw_rdy !== 1'b0)   begin errors++; $display("FAIL rmid_rw_rdy: got %b want 0", bus.rw_rdy); end
    checks++; if (bus.act_stall !== 1'b0) begin errors++; $display("FAIL rmid_act_stall: got %b want 0", bus.act_stall); end
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL rmid_cas_idle: got %b want 1", bus.cas_idle); end
    checks++; if (ovf_err !== 1'b0)      begin errors++; $display("FAIL rmid_ovf_err: got %b want 0", ovf_err); end
    repeat (2) tick();
    reset = 1'b0;
    clear_log();
    repeat (40) tick();
    checks++; if (rw_cyc.size() != 0)  begin errors++; $display("FAIL rmid_no_rw: got %0d want 0", rw_cyc.size()); end
    checks++; if (cas_cyc.size() != 0) begin errors++; $display("FAIL rmid_no_cas: got %0d want 0", cas_cyc.size()); end
    checks++; if (bus.cas_idle !== 1'b1) begin errors++; $display("FAIL rmid_idle_after: got %b want 1", bus.cas_idle); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.act_rdy  = 1'b0;
    bus.act_rw   = 2'b00;
    bus.act_addr = mk_addr(0);
    cl = '0; cwl = '0; rd_pre = '0; wr_pre = '0; tccd = 6'd1;
    config_done = 1'b0;
    test_reset();
    test_single_read();
    test_invalid_rw();
    test_back_to_back();
    test_mixed();
    test_full_pop_enq();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
